// File: rtl/cnn_pkg.sv
// Shared definitions for the first-layer CNN front end.
// Holds the default frame/pixel/kernel sizes, the window generator FSM
// state type and the shift-register tap index helper.
package cnn_pkg;

  localparam int F_DEF = 28;  // frame width and height in pixels
  localparam int B_DEF = 8;   // pixel width in bits
  localparam int K_DEF = 3;   // kernel size, only 3 is supported

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Shift-register position feeding tap (dy,dx); sr[0] is the newest pixel.
  function automatic int tap_idx(input int dy, input int dx, input int f);
    return 2 * f + 2 - dy * f - dx;
  endfunction

endpackage

// File: rtl/window_tap_sr.sv
// Sliding pixel shift register for the 3x3 window generator.
// Ports:
//   i_clk       clock
//   i_shift     shift one position this cycle
//   i_zero_fill shift in zero instead of i_pixel
//   i_pixel     incoming pixel
//   o_taps      K*K taps, tap (dy,dx) at [(dy*K+dx)*B +: B]
// The taps are taken from the post-shift contents so the parent can
// register a window in the same edge that stores the triggering pixel.
// The storage has no reset: stale entries only reach taps the parent masks.
module window_tap_sr
  import cnn_pkg::*;
#(
  parameter int F = F_DEF,
  parameter int B = B_DEF,
  parameter int K = K_DEF
) (
  input  logic             i_clk,
  input  logic             i_shift,
  input  logic             i_zero_fill,
  input  logic [B-1:0]     i_pixel,
  output logic [K*K*B-1:0] o_taps
);

  localparam int DEPTH = 2 * F + 3;

  logic [B-1:0] sr_q [DEPTH];
  logic [B-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d = sr_q;
    if (i_shift) begin
      sr_d[0] = i_zero_fill ? '0 : i_pixel;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    sr_q <= sr_d;
  end

  for (genvar dy = 0; dy < K; dy++) begin : g_row
    for (genvar dx = 0; dx < K; dx++) begin : g_col
      assign o_taps[(dy*K+dx)*B +: B] = sr_d[tap_idx(dy, dx, F)];
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-to-window generator: turns an FxF raster pixel stream into one
// zero-padded 3x3 window per output valid, in raster order of the centre.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pixel, i_pixel_valid raster input, no backpressure (ignored while busy)
//   o_window              taps, (dy,dx) at [(dy*K+dx)*B +: B]
//   o_window_valid        window/row/col valid
//   o_row, o_col          window centre position
//   o_last                marks window (F-1,F-1)
//   o_busy                draining the last F+1 windows, input ignored
//
// state | meaning
// FILL  | collecting the first F+1 pixels, no windows yet
// RUN   | each accepted pixel emits one window
// DRAIN | one window per cycle with zero shift-in until the last window
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int F = F_DEF,
  parameter int B = B_DEF,
  parameter int K = K_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [B-1:0]         i_pixel,
  input  logic                 i_pixel_valid,
  output logic [K*K*B-1:0]     o_window,
  output logic                 o_window_valid,
  output logic [$clog2(F)-1:0] o_row,
  output logic [$clog2(F)-1:0] o_col,
  output logic                 o_last,
  output logic                 o_busy
);

  localparam int RW = $clog2(F);
  localparam int PW = $clog2(F * F);
  localparam logic [PW-1:0] P_FIRST = PW'(F + 1);
  localparam logic [PW-1:0] P_LAST  = PW'(F * F - 1);
  localparam logic [RW-1:0] POS_MAX = RW'(F - 1);

  state_e             state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  // position of the next window to be emitted
  logic [RW-1:0]      wr_q, wr_d, wc_q, wc_d;
  logic [K*K*B-1:0]   window_q, win_d, taps;
  logic               valid_q, last_q, busy_q;
  logic [RW-1:0]      row_q, col_q;
  logic               accept, emit, last_pos;

  assign accept   = i_pixel_valid && (state_q != DRAIN);
  assign last_pos = (wr_q == POS_MAX) && (wc_q == POS_MAX);

  window_tap_sr #(.F(F), .B(B), .K(K)) u_sr (
    .i_clk       (i_clk),
    .i_shift     (accept || (state_q == DRAIN)),
    .i_zero_fill (state_q == DRAIN),
    .i_pixel     (i_pixel),
    .o_taps      (taps)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    emit    = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          p_d = p_q + 1'b1;
          if (p_q == P_FIRST) begin
            emit    = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          emit = 1'b1;
          if (p_q == P_LAST) begin
            p_d     = '0;
            state_d = DRAIN;
          end else begin
            p_d = p_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        emit = 1'b1;
        if (last_pos) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    wr_d = wr_q;
    wc_d = wc_q;
    if (emit) begin
      if (wc_q == POS_MAX) begin
        wc_d = '0;
        wr_d = (wr_q == POS_MAX) ? '0 : wr_q + 1'b1;
      end else begin
        wc_d = wc_q + 1'b1;
      end
    end
  end

  // Zero padding: drop taps whose row or column falls outside the frame.
  // This also hides wrapped pixels from the neighbouring row and anything
  // stale left in the shift register from a previous frame.
  always_comb begin
    win_d = taps;
    for (int dy = 0; dy < K; dy++) begin
      for (int dx = 0; dx < K; dx++) begin
        if ((dy == 0 && wr_q == '0) || (dy == K - 1 && wr_q == POS_MAX) ||
            (dx == 0 && wc_q == '0) || (dx == K - 1 && wc_q == POS_MAX)) begin
          win_d[(dy*K+dx)*B +: B] = '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= FILL;
      p_q      <= '0;
      wr_q     <= '0;
      wc_q     <= '0;
      window_q <= '0;
      valid_q  <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      valid_q <= emit;
      last_q  <= emit && last_pos;
      busy_q  <= (state_d == DRAIN);
      if (emit) begin
        window_q <= win_d;
        row_q    <= wr_q;
        col_q    <= wc_q;
      end
    end
  end

  assign o_window       = window_q;
  assign o_window_valid = valid_q;
  assign o_row          = row_q;
  assign o_col          = col_q;
  assign o_last         = last_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

  localparam int F = 28;
  localparam int B = 8;
  localparam int K = 3;
  localparam int NPIX = F * F;

  logic             clk = 1'b0;
  logic             i_rst;
  logic [B-1:0]     i_pixel;
  logic             i_pixel_valid;
  logic [K*K*B-1:0] o_window;
  logic             o_window_valid;
  logic [4:0]       o_row, o_col;
  logic             o_last, o_busy;

  conv_window_gen #(.F(F), .B(B), .K(K)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_pixel        (i_pixel),
    .i_pixel_valid  (i_pixel_valid),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .o_row          (o_row),
    .o_col          (o_col),
    .o_last         (o_last),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int t0, input int t1, input int t2,
                                        input int t3, input int t4, input int t5,
                                        input int t6, input int t7, input int t8);
    return {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4), 8'(t3), 8'(t2), 8'(t1), 8'(t0)};
  endfunction

  // Reference window for linear window index w, pixel(r,c) = (r*F+c) mod 256.
  function automatic logic [71:0] exp_win(input int w);
    logic [71:0] v;
    int r, c, rr, cc;
    v = '0;
    r = w / F;
    c = w % F;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        rr = r + dy - 1;
        cc = c + dx - 1;
        if (rr >= 0 && rr < F && cc >= 0 && cc < F)
          v[(dy*3+dx)*8 +: 8] = 8'((rr * F + cc) % 256);
      end
    end
    return v;
  endfunction

  logic [71:0] W00, W57, WLAST;

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_w = 0, valid_cnt = 0, frames_done = 0, last_cnt = 0;
  int first_valid_cyc = 0, busy_rise_cyc = 0, busy_run = 0, busy_len = 0;
  logic [71:0] win00 = '0, win57 = '0, winlast = '0;
  logic prev_busy = 1'b0, prev_rst = 1'b1;

  always @(negedge clk) begin
    if (i_rst) begin
      if (prev_rst) check("rst_quiet", {o_window_valid, o_last, o_busy}, 72'd0);
      exp_w     = 0;
      valid_cnt = 0;
    end else if (o_window_valid) begin
      if (exp_w == 0) begin
        first_valid_cyc = cyc;
        win00 = o_window;
      end
      if (exp_w == 5 * F + 7) win57 = o_window;
      check("win_pos", {o_row, o_col, o_last},
            {5'(exp_w / F), 5'(exp_w % F), (exp_w == NPIX - 1)});
      check("win_data", o_window, exp_win(exp_w));
      valid_cnt++;
      if (exp_w == NPIX - 1) begin
        winlast   = o_window;
        last_cnt  = valid_cnt;
        valid_cnt = 0;
        exp_w     = 0;
        frames_done++;
      end else begin
        exp_w++;
      end
    end
    if (o_busy && !prev_busy) begin
      busy_rise_cyc = cyc;
      busy_run = 0;
    end
    if (o_busy) busy_run++;
    if (!o_busy && prev_busy) busy_len = busy_run;
    prev_busy = o_busy;
    prev_rst  = i_rst;
  end

  // ---------------- driver ----------------
  int p29_cyc = 0;

  task automatic send_frame(input bit gaps, input int npix, output int last_cyc);
    last_cyc = 0;
    for (int p = 0; p < npix; p++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          i_pixel_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      i_pixel_valid = 1'b1;
      i_pixel = 8'(p % 256);
      if (p == 29) p29_cyc = cyc;
      last_cyc = cyc;
      @(posedge clk); #1;
    end
    i_pixel_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int limit);
    int t;
    t = 0;
    while (frames_done < target && t < limit) begin
      @(posedge clk); #1;
      t++;
    end
    check("frame_done", 72'(frames_done >= target), 72'd1);
  endtask

  int lc, fa;

  initial begin
    W00   = pack9(0, 0, 0, 0, 0, 1, 0, 28, 29);
    W57   = pack9(118, 119, 120, 146, 147, 148, 174, 175, 176);
    WLAST = pack9(242, 243, 0, 14, 15, 0, 0, 0, 0);

    i_rst = 1'b1;
    i_pixel_valid = 1'b0;
    i_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_window", o_window, 72'd0);
    check("rst_valid", 72'(o_window_valid), 72'd0);
    check("rst_row", 72'(o_row), 72'd0);
    check("rst_col", 72'(o_col), 72'd0);
    check("rst_last", 72'(o_last), 72'd0);
    check("rst_busy", 72'(o_busy), 72'd0);
    i_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Continuous frame, pixels driven throughout DRAIN must be ignored.
    fa = frames_done;
    send_frame(1'b0, NPIX, lc);
    for (int i = 0; i < 29; i++) begin
      i_pixel_valid = 1'b1;
      i_pixel = 8'hAA;
      @(posedge clk); #1;
    end
    i_pixel_valid = 1'b0;
    wait_frames(fa + 1, 200);
    check("first_valid_lat", 72'(first_valid_cyc), 72'(p29_cyc + 1));
    check("win00_taps", win00, W00);
    check("win57_taps", win57, W57);
    check("winlast_taps", winlast, WLAST);
    check("frame_count", 72'(last_cnt), 72'(NPIX));
    check("busy_rise", 72'(busy_rise_cyc), 72'(lc + 1));
    check("busy_len", 72'(busy_len), 72'd29);
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_frame", 72'(o_window_valid), 72'd0);

    // Random valid gaps.
    win00 = '0;
    win57 = '0;
    fa = frames_done;
    send_frame(1'b1, NPIX, lc);
    wait_frames(fa + 1, 200);
    check("gap_win00", win00, W00);
    check("gap_win57", win57, W57);
    check("gap_count", 72'(last_cnt), 72'(NPIX));
    check("gap_busy_len", 72'(busy_len), 72'd29);
    repeat (5) @(posedge clk);
    #1;

    // Reset after pixel 300, then a fresh frame.
    send_frame(1'b0, 301, lc);
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_valid", 72'(o_window_valid), 72'd0);
    check("midrst_pos", 72'({o_row, o_col}), 72'd0);
    i_rst = 1'b0;
    win00 = '0;
    fa = frames_done;
    send_frame(1'b0, NPIX, lc);
    wait_frames(fa + 1, 200);
    check("midrst_win00", win00, W00);
    check("midrst_count", 72'(last_cnt), 72'(NPIX));
    repeat (5) @(posedge clk);
    #1;

    // Back-to-back frames: frame 2 starts in the cycle o_busy falls.
    fa = frames_done;
    send_frame(1'b0, NPIX, lc);
    repeat (29) @(posedge clk);
    #1;
    check("b2b_busy_fell", 72'(o_busy), 72'd0);
    win00 = '0;
    send_frame(1'b0, NPIX, lc);
    wait_frames(fa + 2, 200);
    check("b2b_win00", win00, W00);
    check("b2b_count", 72'(last_cnt), 72'(NPIX));
    check("b2b_winlast", winlast, WLAST);
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
